// File: rtl/rotate_pkg.sv
// rotate_pkg: shared constants and types for the rotated frame-buffer writer.
// Holds the address width, default geometry and the writer state encoding.

package rotate_pkg;

    // Write address width; DISP_W*WIDTH-1 must stay below 2**ADDR_W.
    localparam int ADDR_W = 20;

    // Default geometry: WIDTH is the stored row length (display height),
    // DISP_W is the display width in pixels.
    localparam int DEF_WIDTH  = 640;
    localparam int DEF_DISP_W = 480;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/rotate_addr_gen.sv
// rotate_addr_gen: incremental rotated-layout address generator.
// Ports: clk_in/rst_in (async, active-high), advance/restart strobes,
// addr (address of the next non-SOF pixel), last (next pixel ends the frame).

module rotate_addr_gen
    import rotate_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DISP_W = DEF_DISP_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              advance,
    input  logic              restart,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int HW = (DISP_W > 1) ? $clog2(DISP_W) : 1;
    localparam int VW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [HW-1:0]     H_MAX = HW'(DISP_W - 1);
    localparam logic [VW-1:0]     V_MAX = VW'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(WIDTH - 1);

    // h/v index the pixel that the next advance will write; row_base
    // is WIDTH-1-v, the address of column h=0 in the current line.
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [VW-1:0] row_base;

    assign last = (h == H_MAX) && (v == V_MAX);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            h        <= '0;
            v        <= '0;
            row_base <= V_MAX;
            addr     <= FIRST;
        end else if (restart) begin
            // The SOF pixel itself goes to WIDTH-1 (written by the top);
            // the generator is primed for h=1, v=0.
            h        <= HW'(1);
            v        <= '0;
            row_base <= V_MAX;
            addr     <= FIRST + STEP;
        end else if (advance) begin
            if (h != H_MAX) begin
                h    <= h + 1'b1;
                addr <= addr + STEP;
            end else if (!last) begin
                // Next display line lands one word lower in every row.
                h        <= '0;
                v        <= v + 1'b1;
                row_base <= row_base - 1'b1;
                addr     <= ADDR_W'(row_base - 1'b1);
            end else begin
                h        <= '0;
                v        <= '0;
                row_base <= V_MAX;
                addr     <= FIRST;
            end
        end
    end

endmodule

// File: rtl/rotate_writer.sv
// rotate_writer: turns a raster pixel stream into rotated frame-buffer writes.
// Ports: clk_in, rst_in (async, active-high); pixel_in/valid_in/sof_in/
// ready_out input handshake; we_out/addr_out/data_out/frame_done_out write
// port gated by wr_ready_in; err_out sticky protocol error, only built when
// ROTATE_WRITER_CHECK_EN is defined (otherwise tied 0).

module rotate_writer
    import rotate_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DISP_W  = DEF_DISP_W,
    parameter int PIXEL_W = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic               valid_in,
    input  logic               sof_in,
    output logic               ready_out,
    input  logic               wr_ready_in,
    output logic               we_out,
    output logic [ADDR_W-1:0]  addr_out,
    output logic [PIXEL_W-1:0] data_out,
    output logic               frame_done_out,
    output logic               err_out
);

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(WIDTH - 1);

    state_t            state;
    logic              accept;
    logic              restart;
    logic              advance;
    logic              gen_last;
    logic [ADDR_W-1:0] gen_addr;

    // The output register can take a new pixel when empty or draining now.
    assign ready_out = !we_out || wr_ready_in;
    assign accept    = valid_in && ready_out;
    // SOF restarts the frame from either state.
    assign restart   = accept && sof_in;
    assign advance   = accept && !sof_in && (state == ACTIVE);

    rotate_addr_gen #(
        .WIDTH  (WIDTH),
        .DISP_W (DISP_W)
    ) u_addr_gen (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .advance (advance),
        .restart (restart),
        .addr    (gen_addr),
        .last    (gen_last)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            we_out         <= 1'b0;
            addr_out       <= '0;
            data_out       <= '0;
            frame_done_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (restart) begin
                        state          <= ACTIVE;
                        we_out         <= 1'b1;
                        addr_out       <= FIRST;
                        data_out       <= pixel_in;
                        frame_done_out <= 1'b0;
                    end else if (wr_ready_in) begin
                        // Non-SOF pixels in IDLE are dropped.
                        we_out         <= 1'b0;
                        frame_done_out <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (restart) begin
                        we_out         <= 1'b1;
                        addr_out       <= FIRST;
                        data_out       <= pixel_in;
                        frame_done_out <= 1'b0;
                    end else if (advance) begin
                        we_out         <= 1'b1;
                        addr_out       <= gen_addr;
                        data_out       <= pixel_in;
                        frame_done_out <= gen_last;
                        if (gen_last) begin
                            state <= IDLE;
                        end
                    end else if (wr_ready_in) begin
                        we_out         <= 1'b0;
                        frame_done_out <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ROTATE_WRITER_CHECK_EN
    logic stray_pixel;
    logic early_sof;

    assign stray_pixel = accept && !sof_in && (state == IDLE);
    assign early_sof   = accept && sof_in && (state == ACTIVE);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            err_out <= 1'b0;
        end else if (stray_pixel || early_sof) begin
            err_out <= 1'b1;
        end
    end
`else
    assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_rotate_writer.sv
// tb_rotate_writer: randomized self-checking bench for rotate_writer.
// Reference model computes addresses directly from h/v raster position.

module tb_rotate_writer;

    localparam int W    = 640;
    localparam int DW   = 480;
    localparam int W_S  = 8;
    localparam int DW_S = 6;
    localparam int NS   = W_S * DW_S;

`ifdef ROTATE_WRITER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [19:0] a;
        logic [15:0] d;
        logic        f;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pixel = '0;
    logic        valid = 1'b0;
    logic        sof = 1'b0;
    logic        wr_ready = 1'b1;

    logic        ready, we, fd, err;
    logic [19:0] addr;
    logic [15:0] data;

    logic        s_ready, s_we, s_fd, s_err;
    logic [19:0] s_addr;
    logic [15:0] s_data;

    int nvec = 0;
    int nbad = 0;

    wr_t q[$];
    bit  m_full;
    bit  m_active;
    bit  m_err;
    int  m_h;
    int  m_v;

    bit  s_mon = 1'b0;
    int  s_cnt;
    bit  s_seen[NS];

    always #5 clk = ~clk;

    rotate_writer dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .pixel_in       (pixel),
        .valid_in       (valid),
        .sof_in         (sof),
        .ready_out      (ready),
        .wr_ready_in    (wr_ready),
        .we_out         (we),
        .addr_out       (addr),
        .data_out       (data),
        .frame_done_out (fd),
        .err_out        (err)
    );

    rotate_writer #(
        .WIDTH  (W_S),
        .DISP_W (DW_S)
    ) dut_s (
        .clk_in         (clk),
        .rst_in         (rst),
        .pixel_in       (pixel),
        .valid_in       (valid),
        .sof_in         (sof),
        .ready_out      (s_ready),
        .wr_ready_in    (wr_ready),
        .we_out         (s_we),
        .addr_out       (s_addr),
        .data_out       (s_data),
        .frame_done_out (s_fd),
        .err_out        (s_err)
    );

    task automatic model_reset();
        q.delete();
        m_full   = 1'b0;
        m_active = 1'b0;
        m_err    = 1'b0;
        m_h      = 0;
        m_v      = 0;
    endtask

    task automatic model_accept(input bit s, input logic [15:0] p,
                                output bit wrote);
        wr_t e;
        wrote = 1'b0;
        if (s) begin
            if (m_active && CHK) m_err = 1'b1;
            e.a = 20'(W - 1);
            e.d = p;
            e.f = 1'b0;
            q.push_back(e);
            wrote    = 1'b1;
            m_active = 1'b1;
            m_h      = 1;
            m_v      = 0;
        end else if (!m_active) begin
            if (CHK) m_err = 1'b1;
        end else begin
            e.a = 20'(W * m_h + (W - 1 - m_v));
            e.d = p;
            e.f = (m_h == DW - 1) && (m_v == W - 1);
            q.push_back(e);
            wrote = 1'b1;
            if (e.f) begin
                m_active = 1'b0;
            end else if (m_h == DW - 1) begin
                m_h = 0;
                m_v++;
            end else begin
                m_h++;
            end
        end
    endtask

    // One clock cycle: drive inputs just after a falling edge, check the
    // registered outputs against the model, advance the model, and return
    // at the next falling edge.
    task automatic step(input bit v, input bit s, input logic [15:0] p,
                        input bit wr);
        bit  er;
        bit  acc;
        bit  wrote;
        wr_t e;
        valid    = v;
        sof      = s;
        pixel    = p;
        wr_ready = wr;
        #1;
        er = !m_full || wr;
        nvec++;
        if (ready !== er || we !== m_full || err !== m_err) begin
            nbad++;
            $display("FAIL handshake: ready=%b we=%b err=%b required %b %b %b",
                     ready, we, err, er, m_full, m_err);
        end
        if (m_full) begin
            nvec++;
            if (q.size() != 1) begin
                nbad++;
                $display("FAIL queue: depth %0d required 1", q.size());
            end else begin
                e = q[0];
                if (addr !== e.a || data !== e.d || fd !== e.f) begin
                    nbad++;
                    $display("FAIL write: addr=%0d data=%h done=%b required %0d %h %b",
                             addr, data, fd, e.a, e.d, e.f);
                end
                if (wr) void'(q.pop_front());
            end
        end
        if (s_mon && s_we && wr) begin
            s_cnt++;
            nvec++;
            if (s_addr >= 20'(NS) || s_seen[s_addr[5:0]]) begin
                nbad++;
                $display("FAIL small_addr: addr=%0d repeated or out of range (limit %0d)",
                         s_addr, NS);
            end else begin
                s_seen[s_addr[5:0]] = 1'b1;
            end
            if (s_cnt == NS) begin
                if (s_fd !== 1'b1 || s_addr !== 20'(W_S * (DW_S - 1))) begin
                    nbad++;
                    $display("FAIL small_last: addr=%0d done=%b required %0d 1",
                             s_addr, s_fd, W_S * (DW_S - 1));
                end
            end else if (s_fd !== 1'b0) begin
                nbad++;
                $display("FAIL small_done: done=%b at write %0d required 0",
                         s_fd, s_cnt);
            end
        end
        acc = v && er;
        wrote = 1'b0;
        if (acc) model_accept(s, p, wrote);
        if (wrote) m_full = 1'b1;
        else if (wr) m_full = 1'b0;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear
    // before any further edge.
    task automatic do_reset();
        valid = 1'b0;
        sof   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        nvec++;
        if (we !== 1'b0 || addr !== '0 || data !== '0 || fd !== 1'b0 ||
            err !== 1'b0 || ready !== 1'b1) begin
            nbad++;
            $display("FAIL reset: we=%b addr=%0d data=%h done=%b err=%b ready=%b required 0 0 0 0 0 1",
                     we, addr, data, fd, err, ready);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step(0, 0, 16'h0, 1);
    endtask

    task automatic test_first_pixels();
        step(1, 1, 16'hAAAA, 1);
        nvec++;
        if (we !== 1'b1 || addr !== 20'd639 || data !== 16'hAAAA) begin
            nbad++;
            $display("FAIL first_pixel: we=%b addr=%0d data=%h required 1 639 aaaa",
                     we, addr, data);
        end
        step(1, 0, 16'h1234, 1);
        nvec++;
        if (addr !== 20'd1279) begin
            nbad++;
            $display("FAIL second_pixel: addr=%0d required 1279", addr);
        end
    endtask

    task automatic test_row_boundary();
        for (int h = 2; h < DW; h++) step(1, 0, 16'($urandom), 1);
        nvec++;
        if (addr !== 20'd307199) begin
            nbad++;
            $display("FAIL row_end: addr=%0d required 307199", addr);
        end
        step(1, 0, 16'($urandom), 1);
        nvec++;
        if (addr !== 20'd638) begin
            nbad++;
            $display("FAIL row_wrap: addr=%0d required 638", addr);
        end
    endtask

    task automatic test_backpressure();
        logic [19:0] ha;
        logic [15:0] hd;
        logic [15:0] p2;
        step(1, 0, 16'h5A5A, 1);
        ha = addr;
        hd = data;
        nvec++;
        if (ha !== 20'd1278) begin
            nbad++;
            $display("FAIL bp_pre: addr=%0d required 1278", ha);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 16'($urandom), 0);
            nvec++;
            if (ready !== 1'b0 || addr !== ha || data !== hd || we !== 1'b1) begin
                nbad++;
                $display("FAIL bp_hold: ready=%b we=%b addr=%0d data=%h required 0 1 %0d %h",
                         ready, we, addr, data, ha, hd);
            end
        end
        p2 = 16'h0F0F;
        step(1, 0, p2, 1);
        nvec++;
        if (addr !== 20'd1918 || data !== p2) begin
            nbad++;
            $display("FAIL bp_resume: addr=%0d data=%h required 1918 %h",
                     addr, data, p2);
        end
    endtask

    task automatic test_mid_sof();
        do_reset();
        step(1, 1, 16'($urandom), 1);
        for (int i = 0; i < 8000; i++) begin
            if (m_h == 10 && m_v == 5) break;
            step(($urandom % 5) != 0, 0, 16'($urandom), ($urandom % 4) != 0);
        end
        step(1, 1, 16'hC0DE, 1);
        nvec++;
        if (addr !== 20'd639 || data !== 16'hC0DE || err !== CHK) begin
            nbad++;
            $display("FAIL mid_sof: addr=%0d data=%h err=%b required 639 c0de %b",
                     addr, data, err, CHK);
        end
        step(1, 0, 16'($urandom), 1);
        nvec++;
        if (addr !== 20'd1279 || err !== CHK) begin
            nbad++;
            $display("FAIL mid_sof_restart: addr=%0d err=%b required 1279 %b",
                     addr, err, CHK);
        end
    endtask

    task automatic test_idle_discard();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 16'($urandom), 1);
            nvec++;
            if (we !== 1'b0 || err !== CHK) begin
                nbad++;
                $display("FAIL idle_discard: we=%b err=%b required 0 %b",
                         we, err, CHK);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        step(1, 1, 16'($urandom), 1);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, ($urandom % 500) == 0,
                 16'($urandom), ($urandom % 3) != 0);
        end
        step(0, 0, 16'h0, 1);
        step(0, 0, 16'h0, 1);
        nvec++;
        if (q.size() != 0 || we !== 1'b0) begin
            nbad++;
            $display("FAIL drain: pending=%0d we=%b required 0 0", q.size(), we);
        end
    endtask

    task automatic test_full_frame();
        int seen_n;
        do_reset();
        s_cnt = 0;
        for (int i = 0; i < NS; i++) s_seen[i] = 1'b0;
        s_mon = 1'b1;
        step(1, 1, 16'($urandom), 1);
        for (int i = 1; i < NS; i++) step(1, 0, 16'($urandom), 1);
        step(1, 0, 16'hBEEF, 1);
        s_mon = 1'b0;
        nvec++;
        if (s_we !== 1'b0) begin
            nbad++;
            $display("FAIL small_idle: we=%b required 0", s_we);
        end
        seen_n = 0;
        for (int i = 0; i < NS; i++) if (s_seen[i]) seen_n++;
        nvec++;
        if (s_cnt != NS || seen_n != NS) begin
            nbad++;
            $display("FAIL small_frame: writes=%0d distinct=%0d required %0d %0d",
                     s_cnt, seen_n, NS, NS);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1, 1, 16'($urandom), 1);
        for (int i = 0; i < 5; i++) step(1, 0, 16'($urandom), 1);
        step(1, 0, 16'($urandom), 0);
        do_reset();
        step(1, 1, 16'h7777, 1);
        nvec++;
        if (we !== 1'b1 || addr !== 20'd639 || data !== 16'h7777) begin
            nbad++;
            $display("FAIL post_reset: we=%b addr=%0d data=%h required 1 639 7777",
                     we, addr, data);
        end
        step(0, 0, 16'h0, 1);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_first_pixels();
        test_row_boundary();
        test_backpressure();
        test_mid_sof();
        test_idle_discard();
        test_random();
        test_full_frame();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/rotate_writer.md
# rotate_writer

Write-side companion to the rotated frame-buffer read path. Accepts a pixel stream in display orientation (raster order, column-fastest) through a valid/ready handshake and produces frame-buffer write strobes. Addresses are in the rotated layout the display reader expects, `addr = WIDTH*h + (WIDTH-1-v)`. Sits between the image-processing pipeline (binarizer/QR preprocessing output) and the frame-buffer BRAM write port. Addresses are generated incrementally; no multiplier.

## Interface
Parameters:
- `WIDTH`, 640: display height in lines; equals the stored row length.
- `DISP_W`, 480: display width in pixels (`h` range 0..DISP_W-1).
- `PIXEL_W`, 16: pixel data width.

Ports:
- `clk_in`  input  1  system clock; all logic on the rising edge.
- `rst_in`  input  1  reset; asynchronous, active-high.
- `pixel_in`  input  PIXEL_W  pixel data.
- `valid_in`  input  1  `pixel_in` is valid.
- `sof_in`  input  1  qualifies the first pixel of a frame (h=0, v=0); sampled only with `valid_in`.
- `ready_out`  output  1  block accepts a pixel this cycle.
- `wr_ready_in`  input  1  frame-buffer port accepts the presented write.
- `we_out`  output  1  write strobe / output valid.
- `addr_out`  output  20  write address.
- `data_out`  output  PIXEL_W  write data.
- `frame_done_out`  output  1  high together with the write of the last pixel of a frame.
- `err_out`  output  1  sticky protocol-error flag; see Configuration.

## Operation
- Transfer: a pixel is accepted when `valid_in && ready_out`.
- Ready: `ready_out = !we_out || wr_ready_in`, combinational.
- State machine, two states:
  - IDLE: `ready_out` follows the rule above. Accepted pixels without `sof_in` are discarded. An accepted pixel with `sof_in` is written at `WIDTH-1`; then go to ACTIVE with h=1, v=0.
  - ACTIVE: each accepted pixel is written at the current address and the counters advance.
- Counter update per accepted pixel in ACTIVE (`h`, `v`, `row_base = WIDTH-1-v`, `addr`):
  - h < DISP_W-1: h+1, `addr += WIDTH`.
  - h = DISP_W-1, v < WIDTH-1: h=0, v+1, `row_base -= 1`, `addr = row_base-1`.
  - h = DISP_W-1, v = WIDTH-1: last pixel; assert `frame_done_out` with this write; return to IDLE.
- Mid-frame SOF: an `sof_in` pixel accepted in ACTIVE restarts the frame. It is written at `WIDTH-1` and the counters reset to h=1, v=0.
- Arithmetic: `addr` is 20 bits unsigned, never wraps; max `DISP_W*WIDTH-1` must be below 2^20 (default max 307199).

## Timing
- Latency: 1 cycle from accepted input to `we_out`/`addr_out`/`data_out`.
- The output register holds while `we_out && !wr_ready_in`; input is stalled through `ready_out`.
- Output register loads on accept. It clears `we_out` when `wr_ready_in` is high and no new pixel is accepted.
- `frame_done_out` is qualified by `we_out` and held during a stall.
- Reset values: state IDLE, h=v=0, `row_base=WIDTH-1`, `we_out=0`, `addr_out=0`, `data_out=0`, `frame_done_out=0`, `err_out=0`. Hence `ready_out=1` after reset.
- Reset mid-frame: pending write is dropped; the next frame must start with `sof_in`.

## Configuration
- `ROTATE_WRITER_CHECK_EN` defined: `err_out` sets on either event below, and clears only on reset:
  - a non-SOF pixel accepted in IDLE;
  - an SOF pixel accepted in ACTIVE.
  
  Both events behave otherwise as described in Operation.
- Not defined: `err_out` is tied 0 and no check logic is present.

## Structure
- Package `rotate_pkg`:
  - `ADDR_W = 20`;
  - default `WIDTH`/`DISP_W`;
  - state enum `{IDLE, ACTIVE}`.
- Sub-module `rotate_addr_gen`: h/v counters, `row_base`, incremental `addr`, and last-pixel detect. Driven by `advance`/`restart` strobes.
- `rotate_writer`: FSM, handshake, output register, error flag.

## Test plan
- Reset then SOF pixel 0xAAAA with `wr_ready_in=1` -> next cycle `we_out=1`, `addr_out=639`, `data_out=0xAAAA`; 2nd pixel -> `addr_out=1279`.
- Row boundary: h=479,v=0 -> `addr_out=307199`; next pixel (h=0,v=1) -> `addr_out=638`.
- Full frame (307200 pixels, no stalls) -> final write `addr_out=306560` with `frame_done_out=1`, then IDLE. Every address in 0..307199 is written exactly once.
- Backpressure: `wr_ready_in=0` for 3 cycles mid-row -> `ready_out=0`, outputs held stable, no pixel lost or duplicated.
- Mid-frame SOF at h=10,v=5 -> write at `addr_out=639`, counters restart. With `ROTATE_WRITER_CHECK_EN`, `err_out=1` sticky.
- Non-SOF pixels in IDLE -> no `we_out`. With the macro, `err_out=1`; without it, `err_out` stays 0.
- Async `rst_in` mid-frame -> outputs clear immediately. The next SOF frame writes from `addr_out=639`.
